pulse_mc: RTL and testbench
===========================

# pulse_mc

Multi-channel programmable pulse generator; next generation of the single-channel timing pulse source. Each of CH independent channels runs a phase state machine (delay, rise, high, fall, low) with per-channel timing fields, inverting polarity and a finite or continuous burst count. The block sits on the peripheral bus side as a timing output and interrupt-flag source.

## Interface
- CH, 4, number of channels
- MSB, 7, MSB of every timing field and phase counter
- CYCLEMSB, 3, MSB of per-channel cycle and burst counters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- setb  in  CH  per-channel enable; low forces that channel to IDLE
- v1  in  CH  per-channel idle level; active level is ~v1
- td, tr, pw, tf, period  in  CH*(MSB+1) each  per-channel fields; channel i at bits [i*(MSB+1)+:MSB+1]
- burst  in  CH*(CYCLEMSB+1)  periods per burst; 0 = continuous
- cko  out  CH  pulse output, registered
- rise, fall  out  CH  asserted while the channel is in RISE / FALL
- err  out  CH  combinational configuration error
- done  out  CH  burst complete, held until setb drops
- cycle  out  CH*(CYCLEMSB+1)  completed periods in the current burst

## Operation
- err[i] = (tr==0) | (tf==0) | (period < tr+pw+tf+1). Compare in MSB+3 bits; no wrap.
- Per-channel states: IDLE, DELAY, RISE, HIGH, FALL, LOW, DONE. Each channel has one phase counter cnt (MSB+1 bits).
- Phase lengths in clk cycles:
  - DELAY = td
  - RISE = tr
  - HIGH = pw
  - FALL = tf
  - LOW = period-(tr+pw+tf)
- Zero-length DELAY or HIGH is skipped. The LOW length is at least 1 whenever err=0.
- Phase exit: when cnt == len-1, go to the next phase and load cnt=0. Otherwise cnt increments.
- IDLE -> DELAY, or RISE if td==0, when setb=1 and err=0.
- End of LOW: cycle increments.
  - If burst!=0 and the new cycle==burst, go to DONE.
  - Otherwise go to RISE. td applies only once per burst.
- DONE: done=1 and cko=v1. Stays in DONE until setb=0.
- setb=0 or err=1 in any state: at the next edge, go to IDLE with cnt=0, cycle=0, done=0, cko=v1.
- cko register:
  - Loads ~v1 on the edge that enters HIGH, or enters FALL when pw==0.
  - Loads v1 on the edge that enters LOW.
  - Holds v1 in IDLE, DELAY and DONE.
- rise/fall are decoded from the registered state and are mutually exclusive.
- cycle wraps modulo 2^(CYCLEMSB+1) in continuous mode.
- Channels share only clk and rst (and halt when configured). No cross-channel interaction.

## Timing
- Reset values: state=IDLE, cnt=0, cycle=0, cko=0, rise=0, fall=0, done=0. err is combinational and is not reset.
- First-cycle latency: setb sampled high at edge k moves the state out of IDLE at edge k.
- rise asserts at edge k+td. cko first reaches ~v1 at edge k+td+tr.
- Period in steady state = period cycles exactly. The waveform is identical from period to period.
- Changing timing fields mid-burst takes effect at the next phase-exit comparison. The bench must hold fields stable while setb=1.
- rst overrides everything, including halt.

## Configuration
- PULSE_MC_HALT_EN defined:
  - Adds inputs halt (1) and haltena (CH).
  - While halt & haltena[i], channel i freezes state, cnt, cycle and cko.
  - setb=0 and err still force IDLE during halt.
- PULSE_MC_HALT_EN undefined: halt and haltena do not exist; channels never freeze.

## Test plan
- Ch0 with td=2, tr=1, pw=3, tf=1, period=8, v1=0, burst=0, setb at edge 0 -> rise at edges 2–3, cko=1 over edges 3–7, fall at edges 6–7, cko=0 at edge 7. Next rise at edge 10. cycle increments every 8 cycles.
- Same fields with burst=3 -> exactly 3 pulses, done=1 after edge 26, cko=0. Dropping setb -> IDLE, done=0, cycle=0.
- v1=1 on ch1 with pw=0 -> cko idles high. cko goes low on FALL entry and high again on LOW entry; no HIGH phase.
- err cases: tr=0 -> err=1, channel stays IDLE. period=5 with tr+pw+tf=5 -> err=1. Setting tf=0 mid-burst -> IDLE next edge.
- rst asserted mid-HIGH -> all outputs at reset values at the next edge. With setb held, restart at the following edge.
- With PULSE_MC_HALT_EN: halt for 4 cycles during ch2 LOW -> ch2 period stretches to period+4 while ch3 (haltena=0) is unaffected.

Source files
------------

// File: rtl/pulse_mc.sv
// pulse_mc: multi-channel programmable pulse generator.
// Each channel steps through DELAY/RISE/HIGH/FALL/LOW phases with its own
// timing fields, polarity and burst count. Define PULSE_MC_HALT_EN to add the
// halt/haltena ports that freeze selected channels.

module pulse_mc_ch #(
    parameter int MSB      = 7,
    parameter int CYCLEMSB = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                freeze_i,
    input  logic                setb_i,
    input  logic                v1_i,
    input  logic [MSB:0]        td_i,
    input  logic [MSB:0]        tr_i,
    input  logic [MSB:0]        pw_i,
    input  logic [MSB:0]        tf_i,
    input  logic [MSB:0]        period_i,
    input  logic [CYCLEMSB:0]   burst_i,
    output logic                cko_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                err_o,
    output logic                done_o,
    output logic [CYCLEMSB:0]   cycle_o
);
    // Two extra bits keep tr+pw+tf+1 from wrapping.
    localparam int W  = MSB + 3;
    localparam int CW = MSB + 1;
    localparam int YW = CYCLEMSB + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_RISE, S_HIGH, S_FALL, S_LOW, S_DONE
    } state_t;

    state_t              state_q;
    logic [MSB:0]        cnt_q;
    logic [CYCLEMSB:0]   cycle_q;
    logic                cko_q;

    logic [W-1:0]        sum_w, per_w, len_w, cnt_w;
    logic                last;
    logic [CYCLEMSB:0]   cycle_inc;

    assign sum_w     = {2'b00, tr_i} + {2'b00, pw_i} + {2'b00, tf_i};
    assign per_w     = {2'b00, period_i};
    assign cnt_w     = {2'b00, cnt_q};
    assign err_o     = (tr_i == '0) | (tf_i == '0) | (per_w < sum_w + W'(1));
    assign cycle_inc = cycle_q + YW'(1);

    // Length of the phase currently being timed.
    always_comb begin
        len_w = W'(1);
        case (state_q)
            S_DELAY: len_w = {2'b00, td_i};
            S_RISE:  len_w = {2'b00, tr_i};
            S_HIGH:  len_w = {2'b00, pw_i};
            S_FALL:  len_w = {2'b00, tf_i};
            S_LOW:   len_w = per_w - sum_w;
            default: len_w = W'(1);
        endcase
    end

    // Counting up to len-1 without forming len-1, so len never underflows.
    assign last = (cnt_w + W'(1) == len_w);

    // Phase state machine with registered pulse output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cycle_q <= '0;
            cko_q   <= 1'b0;
        end else if (!setb_i || err_o) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cycle_q <= '0;
            cko_q   <= v1_i;
        end else if (!freeze_i) begin
            case (state_q)
                S_IDLE: begin
                    cnt_q   <= '0;
                    cycle_q <= '0;
                    cko_q   <= v1_i;
                    state_q <= (td_i == '0) ? S_RISE : S_DELAY;
                end
                S_DELAY: begin
                    cko_q <= v1_i;
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= S_RISE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RISE: begin
                    if (last) begin
                        cnt_q   <= '0;
                        cko_q   <= ~v1_i;
                        state_q <= (pw_i == '0) ? S_FALL : S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_HIGH: begin
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= S_FALL;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FALL: begin
                    if (last) begin
                        cnt_q   <= '0;
                        cko_q   <= v1_i;
                        state_q <= S_LOW;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_LOW: begin
                    if (last) begin
                        cnt_q   <= '0;
                        cycle_q <= cycle_inc;
                        // td is not replayed between periods of a burst.
                        if (burst_i != '0 && cycle_inc == burst_i)
                            state_q <= S_DONE;
                        else
                            state_q <= S_RISE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    cko_q <= v1_i;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    cycle_q <= '0;
                    cko_q   <= v1_i;
                end
            endcase
        end
    end

    assign cko_o   = cko_q;
    assign rise_o  = (state_q == S_RISE);
    assign fall_o  = (state_q == S_FALL);
    assign done_o  = (state_q == S_DONE);
    assign cycle_o = cycle_q;
endmodule

module pulse_mc #(
    parameter int CH       = 4,
    parameter int MSB      = 7,
    parameter int CYCLEMSB = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [CH-1:0]                 setb_i,
    input  logic [CH-1:0]                 v1_i,
    input  logic [CH-1:0][MSB:0]          td_i,
    input  logic [CH-1:0][MSB:0]          tr_i,
    input  logic [CH-1:0][MSB:0]          pw_i,
    input  logic [CH-1:0][MSB:0]          tf_i,
    input  logic [CH-1:0][MSB:0]          period_i,
    input  logic [CH-1:0][CYCLEMSB:0]     burst_i,
    output logic [CH-1:0]                 cko_o,
    output logic [CH-1:0]                 rise_o,
    output logic [CH-1:0]                 fall_o,
    output logic [CH-1:0]                 err_o,
    output logic [CH-1:0]                 done_o,
    output logic [CH-1:0][CYCLEMSB:0]     cycle_o
`ifdef PULSE_MC_HALT_EN
    ,
    input  logic                          halt_i,
    input  logic [CH-1:0]                 haltena_i
`endif
);
    logic [CH-1:0] freeze;

`ifdef PULSE_MC_HALT_EN
    assign freeze = {CH{halt_i}} & haltena_i;
`else
    assign freeze = '0;
`endif

    // One independent phase engine per channel.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        pulse_mc_ch #(.MSB(MSB), .CYCLEMSB(CYCLEMSB)) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .freeze_i (freeze[i]),
            .setb_i   (setb_i[i]),
            .v1_i     (v1_i[i]),
            .td_i     (td_i[i]),
            .tr_i     (tr_i[i]),
            .pw_i     (pw_i[i]),
            .tf_i     (tf_i[i]),
            .period_i (period_i[i]),
            .burst_i  (burst_i[i]),
            .cko_o    (cko_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i]),
            .err_o    (err_o[i]),
            .done_o   (done_o[i]),
            .cycle_o  (cycle_o[i])
        );
    end
endmodule

// File: tb/tb_pulse_mc.sv
// Directed bench for pulse_mc: waveform table for ch0, err table, and
// hand sequences for burst, polarity, mid-burst error, reset and halt.
module tb_pulse_mc;
    logic clk = 1'b0, rst;
    logic [3:0] setb, v1;
    logic [3:0][7:0] td, tr, pw, tf, per;
    logic [3:0][3:0] burst;
    logic [3:0] cko, rise, fall, err, done;
    logic [3:0][3:0] cycle;
`ifdef PULSE_MC_HALT_EN
    logic halt;
    logic [3:0] haltena;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_mc dut (
        .clk_i(clk), .rst_i(rst), .setb_i(setb), .v1_i(v1),
        .td_i(td), .tr_i(tr), .pw_i(pw), .tf_i(tf), .period_i(per),
        .burst_i(burst), .cko_o(cko), .rise_o(rise), .fall_o(fall),
        .err_o(err), .done_o(done), .cycle_o(cycle)
`ifdef PULSE_MC_HALT_EN
        , .halt_i(halt), .haltena_i(haltena)
`endif
    );

    typedef struct { int n; logic cko; logic rise; logic fall; logic [3:0] cyc; } wvec_t;
    typedef struct { logic [7:0] tr; logic [7:0] pw; logic [7:0] tf; logic [7:0] per; logic err; } evec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    initial begin
        wvec_t wt[13];
        evec_t et[7];
        int ed;
        int pulses;
        logic prev;
        logic [6:0] e_cko, e_rise, e_fall;

        // ch0: td=2 tr=1 pw=3 tf=1 period=8, setb high at edge 0
        wt[0]  = '{0,  1'b0, 1'b0, 1'b0, 4'd0};
        wt[1]  = '{1,  1'b0, 1'b0, 1'b0, 4'd0};
        wt[2]  = '{2,  1'b0, 1'b1, 1'b0, 4'd0};
        wt[3]  = '{3,  1'b1, 1'b0, 1'b0, 4'd0};
        wt[4]  = '{5,  1'b1, 1'b0, 1'b0, 4'd0};
        wt[5]  = '{6,  1'b1, 1'b0, 1'b1, 4'd0};
        wt[6]  = '{7,  1'b0, 1'b0, 1'b0, 4'd0};
        wt[7]  = '{9,  1'b0, 1'b0, 1'b0, 4'd0};
        wt[8]  = '{10, 1'b0, 1'b1, 1'b0, 4'd1};
        wt[9]  = '{11, 1'b1, 1'b0, 1'b0, 4'd1};
        wt[10] = '{14, 1'b1, 1'b0, 1'b1, 4'd1};
        wt[11] = '{15, 1'b0, 1'b0, 1'b0, 4'd1};
        wt[12] = '{18, 1'b0, 1'b1, 1'b0, 4'd2};

        et[0] = '{8'd0,   8'd1,   8'd1,   8'd8,   1'b1};
        et[1] = '{8'd1,   8'd1,   8'd0,   8'd8,   1'b1};
        et[2] = '{8'd1,   8'd3,   8'd1,   8'd5,   1'b1};
        et[3] = '{8'd1,   8'd3,   8'd1,   8'd6,   1'b0};
        et[4] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b1};
        et[5] = '{8'd1,   8'd0,   8'd1,   8'd3,   1'b0};
        et[6] = '{8'd1,   8'd0,   8'd1,   8'd2,   1'b1};

        rst = 1'b1; setb = '0; v1 = '0; burst = '0;
        for (int i = 0; i < 4; i++) begin
            td[i] = 8'd0; tr[i] = 8'd1; pw[i] = 8'd1; tf[i] = 8'd1; per[i] = 8'd8;
        end
`ifdef PULSE_MC_HALT_EN
        halt = 1'b0; haltena = '0;
`endif
        tick(); tick();
        chk("rst_cko", 32'(cko), 0);
        chk("rst_rise", 32'(rise), 0);
        chk("rst_fall", 32'(fall), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cycle", 32'(cycle), 0);
        rst = 1'b0;

        // Configuration error table on ch3
        for (int i = 0; i < 7; i++) begin
            tr[3] = et[i].tr; pw[3] = et[i].pw; tf[3] = et[i].tf; per[3] = et[i].per;
            #1;
            chk($sformatf("err_vec%0d", i), 32'(err[3]), 32'(et[i].err));
        end
        // err keeps an enabled channel in IDLE
        tr[3] = 8'd0; pw[3] = 8'd1; tf[3] = 8'd1; per[3] = 8'd8; setb[3] = 1'b1;
        tick(); tick(); tick();
        chk("err_idle_rise", 32'(rise[3]), 0);
        chk("err_idle_cycle", 32'(cycle[3]), 0);
        setb[3] = 1'b0; tr[3] = 8'd1;
        tick();

        // ch0 continuous waveform
        td[0] = 8'd2; tr[0] = 8'd1; pw[0] = 8'd3; tf[0] = 8'd1; per[0] = 8'd8;
        setb[0] = 1'b1;
        ed = -1;
        for (int i = 0; i < 13; i++) begin
            while (ed < wt[i].n) begin tick(); ed++; end
            chk($sformatf("wave_cko_e%0d", wt[i].n), 32'(cko[0]), 32'(wt[i].cko));
            chk($sformatf("wave_rise_e%0d", wt[i].n), 32'(rise[0]), 32'(wt[i].rise));
            chk($sformatf("wave_fall_e%0d", wt[i].n), 32'(fall[0]), 32'(wt[i].fall));
            chk($sformatf("wave_cyc_e%0d", wt[i].n), 32'(cycle[0]), 32'(wt[i].cyc));
        end

        // tf=0 mid-burst (in HIGH) -> IDLE on the next edge
        tick(); tick();
        chk("midhigh_cko", 32'(cko[0]), 1);
        tf[0] = 8'd0;
        #1;
        chk("tf0_err", 32'(err[0]), 1);
        tick();
        chk("tf0_cko", 32'(cko[0]), 0);
        chk("tf0_cycle", 32'(cycle[0]), 0);
        tick();
        chk("tf0_rise", 32'(rise[0]), 0);

        // rst mid-HIGH, setb held -> restart the edge after release
        tf[0] = 8'd1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("prerst_cko", 32'(cko[0]), 1);
        rst = 1'b1;
        tick();
        chk("rstmid_cko", 32'(cko), 0);
        chk("rstmid_rise", 32'(rise), 0);
        chk("rstmid_cycle", 32'(cycle), 0);
        rst = 1'b0;
        tick();
        chk("restart_e0_rise", 32'(rise[0]), 0);
        tick(); tick();
        chk("restart_e2_rise", 32'(rise[0]), 1);

        // burst=3 on ch0
        setb[0] = 1'b0;
        tick();
        burst[0] = 4'd3; setb[0] = 1'b1;
        pulses = 0; prev = cko[0];
        for (int e = 0; e <= 30; e++) begin
            tick();
            if (cko[0] && !prev) pulses++;
            prev = cko[0];
            if (e == 25) begin
                chk("burst_e25_done", 32'(done[0]), 0);
                chk("burst_e25_cycle", 32'(cycle[0]), 2);
            end
            if (e == 26) begin
                chk("burst_e26_done", 32'(done[0]), 1);
                chk("burst_e26_cko", 32'(cko[0]), 0);
                chk("burst_e26_cycle", 32'(cycle[0]), 3);
            end
        end
        chk("burst_e30_done", 32'(done[0]), 1);
        chk("burst_pulses", 32'(pulses), 3);
        setb[0] = 1'b0;
        tick();
        chk("burst_drop_done", 32'(done[0]), 0);
        chk("burst_drop_cycle", 32'(cycle[0]), 0);
        chk("burst_drop_cko", 32'(cko[0]), 0);
        burst[0] = 4'd0;

        // ch1 inverted polarity, no HIGH phase
        v1[1] = 1'b1; td[1] = 8'd0; tr[1] = 8'd2; pw[1] = 8'd0; tf[1] = 8'd2; per[1] = 8'd6;
        tick();
        chk("inv_idle_cko", 32'(cko[1]), 1);
        chk("inv_err", 32'(err[1]), 0);
        setb[1] = 1'b1;
        e_cko  = 7'b1110011;  // bit e = edge e
        e_rise = 7'b1000011;
        e_fall = 7'b0001100;
        for (int e = 0; e < 7; e++) begin
            tick();
            chk($sformatf("inv_cko_e%0d", e), 32'(cko[1]), 32'(e_cko[e]));
            chk($sformatf("inv_rise_e%0d", e), 32'(rise[1]), 32'(e_rise[e]));
            chk($sformatf("inv_fall_e%0d", e), 32'(fall[1]), 32'(e_fall[e]));
        end
        chk("inv_cycle", 32'(cycle[1]), 1);
        setb[1] = 1'b0;
        tick();

`ifdef PULSE_MC_HALT_EN
        // halt during LOW stretches ch2 by 4, ch3 unaffected
        for (int i = 2; i < 4; i++) begin
            td[i] = 8'd0; tr[i] = 8'd1; pw[i] = 8'd1; tf[i] = 8'd1; per[i] = 8'd6;
        end
        haltena = 4'b0100;
        setb[3:2] = 2'b11;
        for (int e = 0; e <= 12; e++) begin
            halt = (e >= 4 && e <= 7);
            tick();
            if (e == 6) begin
                chk("halt_e6_rise3", 32'(rise[3]), 1);
                chk("halt_e6_rise2", 32'(rise[2]), 0);
            end
            if (e == 9) chk("halt_e9_rise2", 32'(rise[2]), 0);
            if (e == 10) begin
                chk("halt_e10_rise2", 32'(rise[2]), 1);
                chk("halt_e10_cyc2", 32'(cycle[2]), 1);
            end
            if (e == 12) chk("halt_e12_rise3", 32'(rise[3]), 1);
        end
        halt = 1'b0;
        setb[3:2] = 2'b00;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
